mac_operand_feeder: RTL and testbench
=====================================

# mac_operand_feeder

Operand sequencer that drives the MAC unit from the producer side. It holds a buffered vector of FP32 data/weight pairs, clears the MAC accumulator, and streams the pairs as `Scalar` operands one per cycle. It waits out the MAC pipeline latency, then captures the accumulated `SINGLE` result. It sits between the on-chip vector buffer writer and the MAC, and is the front end for one dot-product lane.

## Interface
- `DEPTH`, 16: buffer entries; maximum vector length.
- `MAC_LATENCY`, 2: cycles from the last valid operand pair until MAC `out` is final.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_en`  in  1  buffer write strobe.
- `wr_addr`  in  $clog2(DEPTH)  buffer write index.
- `wr_data`  in  32  FP32 data operand bits.
- `wr_weight`  in  32  FP32 weight operand bits.
- `start`  in  1  launch one dot product; sampled only in IDLE.
- `len`  in  $clog2(DEPTH)+1  number of pairs; sampled with `start`.
- `busy`  out  1  high whenever state is not IDLE.
- `mac_data`  out  Scalar  data operand to MAC (`value`, `valid`).
- `mac_weight`  out  Scalar  weight operand to MAC; `valid` is identical to `mac_data.valid`.
- `acc_clr_n`  out  1  registered active-low accumulator clear; the integrator ANDs it with `rst_n` into MAC `rst_n`.
- `mac_out`  in  32  MAC accumulated result (`SINGLE`).
- `result`  out  32  captured dot-product result.
- `result_valid`  out  1  one-cycle pulse when `result` is updated.

## Operation
- Reset values: `busy`=0, both operand `valid`=0 and `value`=0, `acc_clr_n`=1, `result`=0, `result_valid`=0. State returns to IDLE.
- The buffer has no reset and keeps its contents across reset.
- FSM states and transitions:
  - IDLE → CLEAR on `start`.
  - CLEAR: exactly 1 cycle, `acc_clr_n`=0. Goes to STREAM, or to DONE if effective len = 0.
  - STREAM: effective len cycles. Entry i is presented with both `valid`=1; the index increments each cycle. Then → DRAIN.
  - DRAIN: MAC_LATENCY cycles, `valid`=0. Then → DONE.
  - DONE: 1 cycle, `result_valid`=1. Then → IDLE.
- Effective len = min(`len`, DEPTH). `len` = 0 yields `result` = 32'h0000_0000; `mac_out` is not sampled in that case.
- `result` is loaded from `mac_out` on the edge entering DONE and holds until the next DONE.
- Both `start` and `wr_en` are ignored while `busy`; the buffer is stable during a run.
- If `start` and `wr_en` are high in the same IDLE cycle, the write completes and the run uses the new entry.
- All outputs are registered; `value` fields are don't-care-free: they hold 0 when `valid`=0.

## Timing
- `start` sampled high at edge E0:
  - cycle 1: CLEAR.
  - cycles 2..len+1: STREAM.
  - cycles len+2..len+1+MAC_LATENCY: DRAIN.
  - cycle len+2+MAC_LATENCY: DONE.
- For len = 0, DONE occurs in cycle 2.
- `busy` rises in cycle 1 and falls after DONE. A new `start` can be sampled in the first IDLE cycle following DONE.
- Reset asserted mid-run: outputs go to reset values immediately (asynchronously). No `result_valid` is issued for the aborted run.

## Configuration
- `MAC_FEED_ZERO_SKIP_EN` defined: a pair where either operand is ±0 (bits[30:0]==0) is emitted with `valid`=0 and `value`=0 during STREAM. It still occupies its cycle, so timing is unchanged.
- `MAC_FEED_ZERO_SKIP_EN` undefined: every STREAM cycle has `valid`=1.

## Structure
- The shared types package holds:
  - the `Scalar` struct (`value`, `valid`);
  - the FP32 width constant behind `SINGLE`;
  - the feeder state enum (IDLE, CLEAR, STREAM, DRAIN, DONE).
- One sub-module, `mac_feed_buffer`: DEPTH×64-bit register file with one synchronous write port and one combinational read port.
- The FSM and counters live in the top-level module.

## Test plan
- Reset: hold `rst_n`=0 → all outputs at their reset values, `busy`=0.
- Load 4 pairs of 5.0/5.0 (0x40A00000), `len`=4, `start`, with a behavioural MAC model:
  - `acc_clr_n` low only in cycle 1;
  - `valid` high in cycles 2–5;
  - `result_valid` in cycle 6+MAC_LATENCY with `result`=0x42C80000 (100.0).
- `len`=0 → `result_valid` in cycle 2, `result`=0, no `valid` cycles.
- `start` and `wr_en` pulsed while busy → no effect on the run or the buffer. `len`=20 with DEPTH=16 → exactly 16 `valid` cycles.
- Assert `rst_n` in the 2nd STREAM cycle → `valid`/`busy` drop immediately and no `result_valid`. The next `start` completes normally with the retained buffer.
- Data {1.0, 0.0, 2.0}, weights all 3.0 → `result` = 9.0 (0x41100000) in both builds.
  - With the macro: `valid` pattern 1,0,1.
  - Without the macro: `valid` pattern 1,1,1.

Source files
------------

// File: rtl/mac_operand_feeder_pkg.sv
// Shared types for the MAC operand feeder: FP32 width, Scalar operand struct, feeder FSM states.
// Optional feature macro used by the feeder top: MAC_FEED_ZERO_SKIP_EN.
package mac_operand_feeder_pkg;

    localparam int SINGLE = 32;

    typedef struct packed {
        logic [SINGLE-1:0] value;
        logic              valid;
    } scalar_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } feeder_state_e;

    // +0 and -0 both count as zero; the sign bit is ignored.
    function automatic logic is_fp_zero(input logic [SINGLE-1:0] f);
        return f[SINGLE-2:0] == '0;
    endfunction

endpackage

// File: rtl/mac_feed_buffer.sv
// DEPTH x 64-bit operand-pair register file: one synchronous write port, one combinational read port.
// Deliberately has no reset so contents survive a feeder reset.
module mac_feed_buffer #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mac_operand_feeder.sv
// Dot-product front end: clears the MAC, streams buffered FP32 pairs, waits the MAC latency, captures the result.
// Define MAC_FEED_ZERO_SKIP_EN to suppress valid on pairs where either operand is +/-0.
module mac_operand_feeder
    import mac_operand_feeder_pkg::*;
#(
    parameter  int DEPTH       = 16,
    parameter  int MAC_LATENCY = 2,
    localparam int AW          = $clog2(DEPTH),
    localparam int LW          = AW + 1,
    localparam int DW          = $clog2(MAC_LATENCY + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [SINGLE-1:0] wr_data,
    input  logic [SINGLE-1:0] wr_weight,
    input  logic              start,
    input  logic [LW-1:0]     len,
    output logic              busy,
    output scalar_t           mac_data,
    output scalar_t           mac_weight,
    output logic              acc_clr_n,
    input  logic [SINGLE-1:0] mac_out,
    output logic [SINGLE-1:0] result,
    output logic              result_valid,
    output feeder_state_e     dbg_state
);

    feeder_state_e     state;
    logic [LW-1:0]     cnt;
    logic [LW-1:0]     eff_len;
    logic [DW-1:0]     dcnt;
    logic [63:0]       rd_pair;
    logic [SINGLE-1:0] rd_data;
    logic [SINGLE-1:0] rd_weight;
    logic [LW-1:0]     eff_len_in;
    logic              pair_live;
    scalar_t           nxt_data;
    scalar_t           nxt_weight;

    // Writes are only accepted in IDLE so the buffer is frozen for the whole run.
    mac_feed_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clk   (clk),
        .we    (wr_en && (state == ST_IDLE)),
        .waddr (wr_addr),
        .wdata ({wr_data, wr_weight}),
        .raddr (cnt[AW-1:0]),
        .rdata (rd_pair)
    );

    assign rd_data    = rd_pair[63:32];
    assign rd_weight  = rd_pair[31:0];
    assign eff_len_in = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;

`ifdef MAC_FEED_ZERO_SKIP_EN
    assign pair_live = !(is_fp_zero(rd_data) || is_fp_zero(rd_weight));
`else
    assign pair_live = 1'b1;
`endif

    always_comb begin
        nxt_data         = '0;
        nxt_weight       = '0;
        nxt_data.valid   = pair_live;
        nxt_weight.valid = pair_live;
        if (pair_live) begin
            nxt_data.value   = rd_data;
            nxt_weight.value = rd_weight;
        end
    end

    // cnt is both the read index and the number of pairs already presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            eff_len      <= '0;
            dcnt         <= '0;
            busy         <= 1'b0;
            mac_data     <= '0;
            mac_weight   <= '0;
            acc_clr_n    <= 1'b1;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    result_valid <= 1'b0;
                    if (start) begin
                        state     <= ST_CLEAR;
                        eff_len   <= eff_len_in;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        acc_clr_n <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    acc_clr_n <= 1'b1;
                    if (eff_len == '0) begin
                        state        <= ST_DONE;
                        result       <= '0;
                        result_valid <= 1'b1;
                    end else begin
                        state      <= ST_STREAM;
                        mac_data   <= nxt_data;
                        mac_weight <= nxt_weight;
                        cnt        <= cnt + LW'(1);
                    end
                end
                ST_STREAM: begin
                    if (cnt == eff_len) begin
                        state      <= ST_DRAIN;
                        mac_data   <= '0;
                        mac_weight <= '0;
                        dcnt       <= DW'(1);
                    end else begin
                        mac_data   <= nxt_data;
                        mac_weight <= nxt_weight;
                        cnt        <= cnt + LW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (dcnt == DW'(MAC_LATENCY)) begin
                        state        <= ST_DONE;
                        result       <= mac_out;
                        result_valid <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                ST_DONE: begin
                    state        <= ST_IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder with a behavioural FP32 MAC (clear, accumulate, registered out).
// Expected valid pattern for the zero-data vector depends on MAC_FEED_ZERO_SKIP_EN.
module tb_mac_operand_feeder;
    import mac_operand_feeder_pkg::*;

    localparam int DEPTH       = 16;
    localparam int MAC_LATENCY = 2;
    localparam int AW          = $clog2(DEPTH);
    localparam int LW          = AW + 1;

    localparam logic [31:0] F_1   = 32'h3F80_0000;
    localparam logic [31:0] F_2   = 32'h4000_0000;
    localparam logic [31:0] F_3   = 32'h4040_0000;
    localparam logic [31:0] F_5   = 32'h40A0_0000;
    localparam logic [31:0] F_9   = 32'h4110_0000;
    localparam logic [31:0] F_25  = 32'h41C8_0000;
    localparam logic [31:0] F_100 = 32'h42C8_0000;
    localparam logic [31:0] F_400 = 32'h43C8_0000;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          wr_en     = 1'b0;
    logic [AW-1:0] wr_addr   = '0;
    logic [31:0]   wr_data   = '0;
    logic [31:0]   wr_weight = '0;
    logic          start     = 1'b0;
    logic [LW-1:0] len       = '0;
    logic          busy;
    scalar_t       mac_data;
    scalar_t       mac_weight;
    logic          acc_clr_n;
    logic [31:0]   mac_out;
    logic [31:0]   result;
    logic          result_valid;
    feeder_state_e dbg_state;

    mac_operand_feeder #(.DEPTH(DEPTH), .MAC_LATENCY(MAC_LATENCY)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_weight    (wr_weight),
        .start        (start),
        .len          (len),
        .busy         (busy),
        .mac_data     (mac_data),
        .mac_weight   (mac_weight),
        .acc_clr_n    (acc_clr_n),
        .mac_out      (mac_out),
        .result       (result),
        .result_valid (result_valid),
        .dbg_state    (dbg_state)
    );

    // behavioural MAC: accumulate stage + registered output stage
    function automatic real f2r(input logic [31:0] b);
        real r;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        r = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return b[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        real         r;
        int          e;
        logic        s;
        logic [22:0] m;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        r = s ? -v : v;
        e = 127;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0) begin r = r * 2.0; e--; end
        m = 23'($rtoi((r - 1.0) * 8388608.0));
        return {s, 8'(e), m};
    endfunction

    logic mac_rst_n;
    real  acc;
    assign mac_rst_n = acc_clr_n & rst_n;

    always @(posedge clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            acc     <= 0.0;
            mac_out <= 32'h0;
        end else begin
            if (mac_data.valid) acc <= acc + f2r(mac_data.value) * f2r(mac_weight.value);
            mac_out <= r2f(acc);
        end
    end

    // scoreboard
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // driver tasks
    task automatic write_pair(input int addr, input logic [31:0] d, input logic [31:0] w);
        @(negedge clk);
        wr_en     = 1'b1;
        wr_addr   = AW'(addr);
        wr_data   = d;
        wr_weight = w;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    int          first_valid, last_valid, n_valid, n_clr, first_clr, rv_cycle, n_rv, n_vdiff;
    logic [31:0] rv_result, first_data, vpat;
    logic        busy_c1, busy_after;

    // Cycle c is the cycle after the c-th rising edge following the start edge.
    task automatic run_vector(input logic [LW-1:0] n, input bit poke);
        @(negedge clk);
        start = 1'b1;
        len   = n;
        first_valid = 0; last_valid = 0; n_valid = 0; n_clr = 0; first_clr = 0;
        rv_cycle = 0; n_rv = 0; n_vdiff = 0; rv_result = 'x; first_data = 'x; vpat = '0;
        busy_c1 = 1'b0; busy_after = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            if (poke && c == 3) begin
                start     = 1'b1;
                len       = LW'(1);
                wr_en     = 1'b1;
                wr_addr   = '0;
                wr_data   = '0;
                wr_weight = '0;
            end
            if (mac_data.valid !== mac_weight.valid) n_vdiff++;
            if (mac_data.valid) begin
                n_valid++;
                if (first_valid == 0) begin
                    first_valid = c;
                    first_data  = mac_data.value;
                end
                last_valid = c;
            end
            if (c >= 2 && c < 34) vpat[c-2] = mac_data.valid;
            if (!acc_clr_n) begin
                n_clr++;
                if (first_clr == 0) first_clr = c;
            end
            if (result_valid) begin
                n_rv++;
                if (rv_cycle == 0) begin
                    rv_cycle  = c;
                    rv_result = result;
                end
            end
            if (c == 1) busy_c1 = busy;
            if (rv_cycle != 0 && c == rv_cycle + 1) busy_after = busy;
        end
    endtask

    initial begin
        logic [2:0] exp_pat;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_data", mac_data, '0);
        check("rst_weight", mac_weight, '0);
        check("rst_clr_n", acc_clr_n, 1);
        check("rst_result", result, 0);
        check("rst_rv", result_valid, 0);
        rst_n = 1'b1;

        // four pairs of 5.0 x 5.0
        for (int i = 0; i < 4; i++) write_pair(i, F_5, F_5);
        run_vector(LW'(4), 1'b0);
        check("l4_first_clr", first_clr, 1);
        check("l4_n_clr", n_clr, 1);
        check("l4_first_valid", first_valid, 2);
        check("l4_last_valid", last_valid, 5);
        check("l4_n_valid", n_valid, 4);
        check("l4_valid_pair", n_vdiff, 0);
        check("l4_data_value", first_data, F_5);
        check("l4_rv_cycle", rv_cycle, 6 + MAC_LATENCY);
        check("l4_n_rv", n_rv, 1);
        check("l4_result", rv_result, F_100);
        check("l4_busy_c1", busy_c1, 1);
        check("l4_busy_after", busy_after, 0);
        check("l4_result_hold", result, F_100);

        // zero-length run
        run_vector(LW'(0), 1'b0);
        check("l0_rv_cycle", rv_cycle, 2);
        check("l0_n_valid", n_valid, 0);
        check("l0_result", rv_result, 0);
        check("l0_n_clr", n_clr, 1);

        // len beyond DEPTH, with start/wr_en pokes while busy
        for (int i = 4; i < DEPTH; i++) write_pair(i, F_5, F_5);
        run_vector(LW'(20), 1'b1);
        check("l20_n_valid", n_valid, DEPTH);
        check("l20_last_valid", last_valid, DEPTH + 1);
        check("l20_rv_cycle", rv_cycle, DEPTH + 2 + MAC_LATENCY);
        check("l20_n_rv", n_rv, 1);
        check("l20_result", rv_result, F_400);
        run_vector(LW'(1), 1'b0);
        check("poke_buffer_kept", rv_result, F_25);

        // reset in the second STREAM cycle
        @(negedge clk);
        start = 1'b1;
        len   = LW'(4);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("mr_valid_before", mac_data.valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_valid_async", mac_data.valid, 0);
        check("mr_busy_async", busy, 0);
        check("mr_clr_n_async", acc_clr_n, 1);
        check("mr_result_async", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_rv  = 0;
        repeat (12) begin
            @(negedge clk);
            if (result_valid) n_rv++;
        end
        check("mr_no_rv", n_rv, 0);
        run_vector(LW'(4), 1'b0);
        check("mr_rerun_rv_cycle", rv_cycle, 6 + MAC_LATENCY);
        check("mr_rerun_result", rv_result, F_100);

        // data {1, 0, 2} x weight 3
        write_pair(0, F_1, F_3);
        write_pair(1, 32'h0, F_3);
        write_pair(2, F_2, F_3);
        run_vector(LW'(3), 1'b0);
`ifdef MAC_FEED_ZERO_SKIP_EN
        exp_pat = 3'b101;
`else
        exp_pat = 3'b111;
`endif
        check("zs_result", rv_result, F_9);
        check("zs_valid_pattern", vpat[2:0], exp_pat);
        check("zs_rv_cycle", rv_cycle, 5 + MAC_LATENCY);
        check("zs_valid_pair", n_vdiff, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
